// File: rtl/alu_issue_ctrl.sv
// ============================================================================
//  Module   : alu_issue_ctrl
//  Function : Single-issue operand fetch / ALU drive / writeback controller
//             with an 8 x 9-bit register file (r0 reads zero).
//             Define ALU_ISSUE_PERF_EN to add the retired_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int DATA_W = 9,
  parameter int NREGS  = 8,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic [IDX_W-1:0]  in_rs,
  input  logic [IDX_W-1:0]  in_rt,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [DATA_W-1:0] wb_data,
  output logic              eq_flag,
`ifdef ALU_ISSUE_PERF_EN
  output logic [15:0]       retired_cnt,
`endif
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [1:0] c_OP_EQ = 2'b10;

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [IDX_W-1:0]  r_rd;
  logic [IDX_W-1:0]  r_rs;
  logic [IDX_W-1:0]  r_rt;
  logic              r_use_imm;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [1:0]        r_alu_sel;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_eq;
  logic [DATA_W-1:0] r_rf [NREGS];

  logic              w_accept;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  // Index 0 is forced to zero on every read port, independent of storage.
  assign w_rs_val = (r_rs == '0)     ? '0 : r_rf[r_rs];
  assign w_rt_val = (r_rt == '0)     ? '0 : r_rf[r_rt];
  assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_sel = r_alu_sel;
  assign wb_data = r_wb_data;
  assign eq_flag = r_eq;
  assign done    = (r_state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      r_rd      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= 2'b00;
      r_wb_data <= '0;
      r_eq      <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= in_op;
            r_rd      <= in_rd;
            r_rs      <= in_rs;
            r_rt      <= in_rt;
            r_use_imm <= in_use_imm;
            r_imm     <= in_imm;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          // Operands land directly in the ALU drive registers so they are
          // stable for the whole EXEC cycle.
          r_alu_a   <= w_rs_val;
          r_alu_b   <= r_use_imm ? r_imm : w_rt_val;
          r_alu_sel <= r_op;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_wb_data <= alu_result;
          r_state   <= S_WB;
        end
        S_WB: begin
          if (r_op == c_OP_EQ) begin
            r_eq <= r_wb_data[0];
          end else if (r_rd != '0) begin
            r_rf[r_rd] <= r_wb_data;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] r_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= 16'd0;
    end else if (r_state == S_WB) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired_cnt = r_retired;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Function : Directed table-driven bench for alu_issue_ctrl with a
//             behavioural 9-bit ALU on the result path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [2:0] in_rd, in_rs, in_rt;
  logic       in_use_imm;
  logic [8:0] in_imm;
  logic [8:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_sel;
  logic       done;
  logic [8:0] wb_data;
  logic       eq_flag;
  logic [2:0] dbg_addr;
  logic [8:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] retired_cnt;
`endif

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .done(done), .wb_data(wb_data), .eq_flag(eq_flag),
`ifdef ALU_ISSUE_PERF_EN
    .retired_cnt(retired_cnt),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, nand, equality, pass-a.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = ~(alu_a & alu_b);
      2'b10: alu_result = {8'd0, (alu_a == alu_b)};
      default: alu_result = alu_a;
    endcase
  end

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] rd, rs, rt;
    logic       use_imm;
    logic [8:0] imm;
    logic [8:0] ea, eb, ewb;
    logic [2:0] daddr;
    logic [8:0] edbg;
    logic       eeq;
  } vec_t;

  vec_t vt[10];

  // Handshake / done monitors.
  int cyc = 0;
  int hs_n = 0;
  int hs_cyc[4];
  int ndone = 0;
  always @(posedge clk) begin
    if (in_valid && in_ready && hs_n < 4) begin
      hs_cyc[hs_n] = cyc;
      hs_n++;
    end
    cyc++;
  end
  always @(negedge clk) if (done === 1'b1) ndone++;

  // Issues one instruction starting from a negedge in IDLE and follows it
  // through READ, EXEC, WB and back to IDLE.
  task automatic apply(input vec_t v);
    chk("ready_idle", 16'(in_ready), 16'd1);
    in_valid = 1'b1; in_op = v.op; in_rd = v.rd; in_rs = v.rs; in_rt = v.rt;
    in_use_imm = v.use_imm; in_imm = v.imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 2'($urandom); in_rd = 3'($urandom); in_rs = 3'($urandom);
    in_rt = 3'($urandom); in_use_imm = 1'($urandom); in_imm = 9'($urandom);
    @(negedge clk);
    chk("ready_read", 16'(in_ready), 16'd0);
    chk("done_read", 16'(done), 16'd0);
    @(negedge clk);
    chk("alu_a", 16'(alu_a), 16'(v.ea));
    chk("alu_b", 16'(alu_b), 16'(v.eb));
    chk("alu_sel", 16'(alu_sel), 16'(v.op));
    chk("done_exec", 16'(done), 16'd0);
    @(negedge clk);
    chk("done_wb", 16'(done), 16'd1);
    chk("wb_data", 16'(wb_data), 16'(v.ewb));
    dbg_addr = v.daddr;
    @(negedge clk);
    chk("ready_back", 16'(in_ready), 16'd1);
    chk("done_after", 16'(done), 16'd0);
    chk("dbg_data", 16'(dbg_data), 16'(v.edbg));
    chk("eq_flag", 16'(eq_flag), 16'(v.eeq));
  endtask

  initial begin
    //          op     rd    rs    rt    imm?  imm     a       b       wb      dbg   dbgval  eq
    vt[0] = '{2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 9'h005, 9'h000, 9'h005, 9'h005, 3'd1, 9'h005, 1'b0};
    vt[1] = '{2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 9'h1FF, 9'h000, 9'h1FF, 9'h1FF, 3'd1, 9'h1FF, 1'b0};
    vt[2] = '{2'b00, 3'd2, 3'd1, 3'd0, 1'b1, 9'h001, 9'h1FF, 9'h001, 9'h000, 3'd2, 9'h000, 1'b0};
    vt[3] = '{2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 9'h0F0, 9'h000, 9'h0F0, 9'h0F0, 3'd1, 9'h0F0, 1'b0};
    vt[4] = '{2'b01, 3'd3, 3'd1, 3'd0, 1'b1, 9'h0FF, 9'h0F0, 9'h0FF, 9'h10F, 3'd3, 9'h10F, 1'b0};
    vt[5] = '{2'b10, 3'd5, 3'd1, 3'd1, 1'b0, 9'h123, 9'h0F0, 9'h0F0, 9'h001, 3'd5, 9'h000, 1'b1};
    vt[6] = '{2'b10, 3'd1, 3'd1, 3'd0, 1'b0, 9'h0F0, 9'h0F0, 9'h000, 9'h000, 3'd1, 9'h0F0, 1'b0};
    vt[7] = '{2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 9'h007, 9'h000, 9'h007, 9'h007, 3'd0, 9'h000, 1'b0};
    vt[8] = '{2'b11, 3'd4, 3'd3, 3'd0, 1'b1, 9'h055, 9'h10F, 9'h055, 9'h10F, 3'd4, 9'h10F, 1'b0};
    vt[9] = '{2'b00, 3'd6, 3'd3, 3'd1, 1'b0, 9'h0AA, 9'h10F, 9'h0F0, 9'h1FF, 3'd6, 9'h1FF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 16'(in_ready), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_sel", 16'(alu_sel), 16'd0);
    chk("rst_wb", 16'(wb_data), 16'd0);
    chk("rst_eq", 16'(eq_flag), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) apply(vt[i]);

    // Set eq_flag, then reset in the middle of an ADD r1 = r0 + 5.
    apply('{2'b10, 3'd0, 3'd3, 3'd3, 1'b0, 9'h000, 9'h10F, 9'h10F, 9'h001, 3'd3, 9'h10F, 1'b1});
    in_valid = 1'b1; in_op = 2'b00; in_rd = 3'd1; in_rs = 3'd0; in_use_imm = 1'b1; in_imm = 9'h005;
    @(posedge clk); #1 in_valid = 1'b0;
    ndone = 0;
    @(negedge clk); @(negedge clk);
    chk("mid_exec_sel", 16'(alu_b), 16'h005);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 16'(in_ready), 16'd0);
    chk("mid_rst_alu_b", 16'(alu_b), 16'd0);
    chk("mid_rst_eq", 16'(eq_flag), 16'd0);
    dbg_addr = 3'd3; #1;
    chk("mid_rst_r3", 16'(dbg_data), 16'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_ready", 16'(in_ready), 16'd1);
    @(negedge clk); @(negedge clk);
    dbg_addr = 3'd1; #1;
    chk("post_rst_r1", 16'(dbg_data), 16'd0);
    chk("post_rst_done", 16'(ndone), 16'd0);
    chk("post_rst_eq", 16'(eq_flag), 16'd0);
    chk("post_rst_ready2", 16'(in_ready), 16'd1);

    // Back-to-back with in_valid held high.
    hs_n = 0;
    in_valid = 1'b1; in_op = 2'b00; in_rd = 3'd1; in_rs = 3'd0; in_use_imm = 1'b1; in_imm = 9'h003;
    @(posedge clk); #1;
    in_rd = 3'd2; in_imm = 9'h004;
    for (int k = 0; k < 10 && hs_n < 2; k++) @(posedge clk);
    #1 in_valid = 1'b0;
    if (hs_n < 2) begin
      chk("bp_second_hs_seen", 16'(hs_n), 16'd2);
    end else begin
      chk("bp_spacing", 16'(hs_cyc[1] - hs_cyc[0]), 16'd4);
      repeat (4) @(negedge clk);
      dbg_addr = 3'd1; #1;
      chk("bp_r1", 16'(dbg_data), 16'h003);
      dbg_addr = 3'd2; #1;
      chk("bp_r2", 16'(dbg_data), 16'h004);
`ifdef ALU_ISSUE_PERF_EN
      chk("retired_cnt", retired_cnt, 16'd2);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
